// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler
// Converts a signed 16-bit value to five BCD digits plus sign with a
// double-dabble shifter, then multiplexes them onto a six-position, active-low
// seven-segment display. The display keeps scanning while a conversion runs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros in digit
// positions 4..1 (ones digit and sign placement are unaffected).
module bcd_display_scheduler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic [5:0]  an
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        sign_q;
    logic [15:0] mag_q;
    logic [19:0] work_q;
    logic [4:0]  cnt_q;
    logic [19:0] disp_q;
    logic        disp_sign_q;
    logic [15:0] scan_cnt_q;
    logic [2:0]  scan_idx_q;

    logic [15:0] abs_val;
    logic [15:0] work_adj;
    logic [3:0]  disp_digit [5];
    logic [4:0]  blank_pos;
    logic [3:0]  digit_sel;
    logic        blank_sel;
    logic [6:0]  seg_sel;

    // Magnitude of the two's-complement input; 16'h8000 maps to 32768, which
    // still fits in 16 unsigned bits.
    assign abs_val = in_data[15] ? (~in_data + 16'd1) : in_data;

    // Add-3 correction for the lower four digits. The top digit never reaches
    // 5 before a shift (magnitudes stay at or below 32768), so it is shifted raw.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign work_adj[gi*4 +: 4] = (work_q[gi*4 +: 4] >= 4'd5) ?
                                         (work_q[gi*4 +: 4] + 4'd3) :
                                         work_q[gi*4 +: 4];
        end
        for (gi = 0; gi < 5; gi++) begin : g_digit
            assign disp_digit[gi] = disp_q[gi*4 +: 4];
        end
    endgenerate

    // Leading-zero blanking mask: a position is blank when it and every
    // higher digit are zero. The ones digit is never blanked.
    assign blank_pos[0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    generate
        for (gi = 1; gi < 5; gi++) begin : g_blank
            if (gi == 4) begin : g_top
                assign blank_pos[gi] = (disp_digit[gi] == 4'd0);
            end else begin : g_mid
                assign blank_pos[gi] = (disp_digit[gi] == 4'd0) && blank_pos[gi+1];
            end
        end
    endgenerate
`else
    assign blank_pos[4:1] = 4'b0000;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Conversion FSM: capture, 16 double-dabble shifts, then publish digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= 16'd0;
            work_q      <= 20'd0;
            cnt_q       <= 5'd0;
            disp_q      <= 20'd0;
            disp_sign_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_data[15];
                        mag_q   <= abs_val;
                        work_q  <= 20'd0;
                        cnt_q   <= 5'd16;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= {work_q[18:16], work_adj, mag_q[15]};
                    mag_q  <= {mag_q[14:0], 1'b0};
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_q      <= work_q;
                    disp_sign_q <= sign_q;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Refresh timer: each position is lit for REFRESH_DIV cycles, then the
    // index advances 0..5 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= 16'd0;
            scan_idx_q <= 3'd0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= 16'd0;
            scan_idx_q <= (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 16'd1;
        end
    end

    // Glyph for the currently selected position.
    always_comb begin
        digit_sel = 4'd0;
        blank_sel = 1'b0;
        case (scan_idx_q)
            3'd0: begin digit_sel = disp_digit[0]; blank_sel = blank_pos[0]; end
            3'd1: begin digit_sel = disp_digit[1]; blank_sel = blank_pos[1]; end
            3'd2: begin digit_sel = disp_digit[2]; blank_sel = blank_pos[2]; end
            3'd3: begin digit_sel = disp_digit[3]; blank_sel = blank_pos[3]; end
            3'd4: begin digit_sel = disp_digit[4]; blank_sel = blank_pos[4]; end
            default: ;
        endcase
        if (scan_idx_q == 3'd5)
            seg_sel = disp_sign_q ? SEG_MINUS : SEG_BLANK;
        else if (blank_sel)
            seg_sel = SEG_BLANK;
        else
            seg_sel = glyph(digit_sel);
    end

    // Outputs are forced dark and not-ready while reset is held, so the display
    // lights and the input opens in the very first cycle after release.
    assign in_ready = rst_n & ~busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign an       = rst_n ? ~(6'd1 << scan_idx_q) : 6'b111111;
    assign seg      = rst_n ? seg_sel : SEG_BLANK;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Self-checking bench for bcd_display_scheduler, run with a short refresh
// period so every display position can be observed quickly.
module tb_bcd_display_scheduler;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [6:0]  seg;
    logic [5:0]  an;

    int n_tests = 0;
    int n_fail  = 0;
    int shown   = 0;   // value the display is expected to hold

    logic [6:0] GLY [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

    bcd_display_scheduler #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Expected glyph for display position pos when showing signed value v.
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int mag;
        int pw;
        bit neg;
        neg = (v < 0);
        mag = neg ? -v : v;
        if (pos == 5) return neg ? 7'b0111111 : 7'b1111111;
        pw = 1;
        for (int i = 0; i < pos; i++) pw = pw * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && mag < pw) return 7'b1111111;
`endif
        return GLY[(mag / pw) % 10];
    endfunction

    // Index of the single low anode bit, or -1 if not exactly one is low.
    function automatic int an_pos(input logic [5:0] a);
        int cnt;
        int p;
        cnt = 0;
        p = -1;
        for (int i = 0; i < 6; i++) if (a[i] === 1'b0) begin cnt++; p = i; end
        return (cnt == 1) ? p : -1;
    endfunction

    task automatic check_display(input int v, input string name);
        bit seen [6];
        int pos;
        for (int i = 0; i < 6; i++) seen[i] = 0;
        for (int i = 0; i < 6 * RD + 6; i++) begin
            @(negedge clk);
            pos = an_pos(an);
            n_tests++;
            if (pos < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: got %b required exactly one low bit", name, an);
            end else if (!seen[pos]) begin
                seen[pos] = 1;
                n_tests++;
                if (seg !== exp_seg(v, pos)) begin
                    n_fail++;
                    $display("FAIL %s seg_pos%0d: got %b required %b (value %0d)",
                             name, pos, seg, exp_seg(v, pos), v);
                end
            end
        end
        for (int p = 0; p < 6; p++) begin
            if (!seen[p]) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s scan_visit: position %0d got unvisited required visited", name, p);
            end
        end
        $display("[TB] display %s value=%0d checked", name, v);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            an !== 6'b111111 || seg !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b an=%b seg=%b required 0 0 0 111111 1111111",
                     in_ready, busy, done, an, seg);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || an !== 6'b111110 || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b an=%b seg=%b required 1 111110 1000000",
                     in_ready, an, seg);
        end
        shown = 0;
        check_display(0, "after_reset");
    endtask

    // One accepted value: latency, handshake flags, display held until done.
    task automatic run_conv(input logic [15:0] v, input string name);
        int vs;
        int done_at;
        int pulses;
        int pos;
        vs = int'($signed(v));
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_idle: got %b required 1", name, in_ready);
        end
        @(posedge clk);
        done_at = -1;
        pulses  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 17) begin
                n_tests++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s flags_k%0d: got rdy=%b busy=%b required 0 1", name, k, in_ready, busy);
                end
                pos = an_pos(an);
                n_tests++;
                if (pos < 0 || seg !== exp_seg(shown, pos)) begin
                    n_fail++;
                    $display("FAIL %s hold_k%0d: got an=%b seg=%b required previous value %0d",
                             name, k, an, seg, shown);
                end
            end
            if (k == 18) begin
                n_tests++;
                if (in_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s flags_k18: got rdy=%b busy=%b required 1 0", name, in_ready, busy);
                end
            end
        end
        n_tests++;
        if (done_at != 17 || pulses != 1) begin
            n_fail++;
            $display("FAIL %s done_timing: got first=%0d pulses=%0d required 17 1", name, done_at, pulses);
        end
        $display("[TB] conv %s in=%h done_at=T+%0d pulses=%0d", name, v, done_at, pulses);
        shown = vs;
        check_display(vs, name);
    endtask

    task automatic test_fixed();
        run_conv(16'd12345, "v12345");
        run_conv(16'hFFFF, "vFFFF");
        run_conv(16'h8000, "v8000");
        run_conv(16'd0, "v0");
        run_conv(16'h7FFF, "v7FFF");
        run_conv(16'd9, "v9");
        run_conv(16'd10000, "v10000");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) run_conv(16'($urandom), "rand");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        int d1;
        int d2;
        int pulses;
        bit rdy_bad;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        in_data  = a;
        in_valid = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; pulses = 0; rdy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) in_data = b;
            if (done === 1'b1) begin
                pulses++;
                if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
            end
            if ((k <= 17 || (k >= 19 && k <= 35)) && in_ready !== 1'b0) rdy_bad = 1;
            if (k == 18 && in_ready !== 1'b1) rdy_bad = 1;
            if (k == 19) in_valid = 1'b0;
        end
        n_tests++;
        if (pulses != 2 || d1 != 17 || d2 != 35) begin
            n_fail++;
            $display("FAIL b2b_done: got pulses=%0d at %0d,%0d required 2 at 17,35", pulses, d1, d2);
        end
        n_tests++;
        if (rdy_bad) begin
            n_fail++;
            $display("FAIL b2b_ready: got wrong in_ready pattern required low 1..17 and 19..35, high 18");
        end
        $display("[TB] b2b a=%h b=%h done at T+%0d and T+%0d", a, b, d1, d2);
        shown = int'($signed(b));
        check_display(shown, "b2b");
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [15:0] c;
        c = 16'd4321;
        @(negedge clk);
        in_data  = c;
        in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            an !== 6'b111111 || seg !== 7'b1111111) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b busy=%b done=%b an=%b seg=%b required 0 0 0 111111 1111111",
                     in_ready, busy, done, an, seg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || an !== 6'b111110) begin
            n_fail++;
            $display("FAIL midreset_release: got rdy=%b busy=%b an=%b required 1 0 111110", in_ready, busy, an);
        end
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midreset_done: got %0d pulses required 0", pulses);
        end
        $display("[TB] midreset abandoned conversion of %0d", c);
        shown = 0;
        check_display(0, "midreset");
    endtask

    task automatic test_scan();
        int pos;
        int prev;
        int run;
        bit started;
        prev = -1; run = 0; started = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            pos = an_pos(an);
            n_tests++;
            if (pos < 0) begin
                n_fail++;
                $display("FAIL scan_onehot: got %b required one low bit", an);
            end else if (pos != prev) begin
                if (started) begin
                    n_tests++;
                    if (run != RD || pos != (prev + 1) % 6) begin
                        n_fail++;
                        $display("FAIL scan_step: got %0d->%0d after %0d cycles required %0d->%0d after %0d",
                                 prev, pos, run, prev, (prev + 1) % 6, RD);
                    end
                end
                if (prev >= 0) started = 1;
                prev = pos;
                run  = 1;
            end else begin
                run++;
            end
        end
        $display("[TB] scan walk checked over 80 cycles");
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
